instr_mem_responder: RTL and testbench

// Instruction-memory responder serving MIPS fetch requests over a valid/ready

---
 rtl/instr_mem_responder.sv | 61 ++++++
 tb/tb_instr_mem_responder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: instruction memory serving valid/ready fetches after a programmable latency
module instr_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [15:0] fetch_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
  logic req_bad;
  assign req_bad = req_addr[1:0] != 2'b00 || req_addr >= LIMIT;
  assign req_ready = rst && state == IDLE;
  // Array is never reset so the program image survives a fetch-side reset
  always_ff @(posedge clk)
    if (rst && ld_we && ld_addr < LIMIT) mem[ld_addr[AW+1:2]] <= ld_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_err <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          resp_err <= req_bad;
          resp_data <= req_bad ? 32'd0 : mem[req_addr[AW+1:2]];
          cnt <= 4'(LATENCY - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == 4'd0) begin
          resp_valid <= 1'b1;
          state <= RESP;
        end else cnt <= cnt - 4'd1;
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          fetch_count <= &fetch_count ? fetch_count : fetch_count + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed checks of the fetch responder at LATENCY 2 and 1
module tb_instr_mem_responder;
  logic clk = 0, rst = 0;
  logic req_valid = 0, resp_ready = 0, ld_we = 0;
  logic [31:0] req_addr = 0, ld_addr = 0, ld_data = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [15:0] fetch_count;
  logic req_valid1 = 0, resp_ready1 = 0;
  logic req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_data1;
  logic [15:0] fetch_count1;
  int n_cmp = 0, n_bad = 0;

  instr_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_count(fetch_count));

  instr_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_addr(req_addr), .req_ready(req_ready1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_data(resp_data1), .resp_err(resp_err1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_count(fetch_count1));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1; ld_addr = a; ld_data = d;
    tick;
    ld_we = 0;
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
    req_valid = 1; req_addr = a;
    tick;
    req_valid = 0;
    chk({tag, "_rv_n0"}, {31'd0, resp_valid}, 0);
    chk({tag, "_rdy_busy"}, {31'd0, req_ready}, 0);
    tick;
    chk({tag, "_rv_n1"}, {31'd0, resp_valid}, 0);
    tick;
    chk({tag, "_rv_n2"}, {31'd0, resp_valid}, 1);
    chk({tag, "_data"}, resp_data, d);
    chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e});
    resp_ready = 1;
    tick;
    resp_ready = 0;
    chk({tag, "_rv_done"}, {31'd0, resp_valid}, 0);
  endtask

  initial begin
    tick;
    chk("rst_rdy", {31'd0, req_ready}, 0);
    chk("rst_rv", {31'd0, resp_valid}, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_err", {31'd0, resp_err}, 0);
    chk("rst_cnt", {16'd0, fetch_count}, 0);
    rst = 1;
    #1;
    chk("post_rst_rdy", {31'd0, req_ready}, 1);
    load(32'd0, 32'h0409_0000);
    load(32'd8, 32'hAAAA_0000);
    load(32'd4092, 32'h1234_5678);
    do_fetch("f0", 32'd0, 32'h0409_0000, 0);
    chk("cnt1", {16'd0, fetch_count}, 1);
    do_fetch("mis", 32'd6, 32'd0, 1);
    chk("cnt2", {16'd0, fetch_count}, 2);
    do_fetch("oor", 32'd4096, 32'd0, 1);
    chk("cnt3", {16'd0, fetch_count}, 3);
    load(32'd4096, 32'hFFFF_FFFF);
    do_fetch("alias", 32'd0, 32'h0409_0000, 0);
    do_fetch("top", 32'd4092, 32'h1234_5678, 0);
    chk("cnt5", {16'd0, fetch_count}, 5);
    // Consumer stalls for five cycles while a second request is waved at a busy responder
    req_valid = 1; req_addr = 32'd0;
    tick;
    req_addr = 32'd4;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rv", {31'd0, resp_valid}, 1);
      chk("stall_data", resp_data, 32'h0409_0000);
      chk("stall_rdy", {31'd0, req_ready}, 0);
      tick;
    end
    resp_ready = 1; req_valid = 0;
    tick;
    resp_ready = 0;
    chk("stall_cnt", {16'd0, fetch_count}, 6);
    chk("stall_rdy_back", {31'd0, req_ready}, 1);
    tick;
    chk("stall_no_extra", {31'd0, resp_valid}, 0);
    req_valid = 1; req_addr = 32'd8;
    tick;
    req_valid = 0;
    ld_we = 1; ld_addr = 32'd8; ld_data = 32'h0000_5555;
    tick;
    ld_we = 0;
    tick;
    chk("late_ld_rv", {31'd0, resp_valid}, 1);
    chk("late_ld_data", resp_data, 32'hAAAA_0000);
    resp_ready = 1;
    tick;
    resp_ready = 0;
    do_fetch("refetch", 32'd8, 32'h0000_5555, 0);
    req_valid = 1; req_addr = 32'd8;
    ld_we = 1; ld_addr = 32'd8; ld_data = 32'h0000_7777;
    tick;
    req_valid = 0; ld_we = 0;
    tick;
    tick;
    chk("same_ld_data", resp_data, 32'h0000_5555);
    resp_ready = 1;
    tick;
    resp_ready = 0;
    do_fetch("refetch2", 32'd8, 32'h0000_7777, 0);
    chk("cnt10", {16'd0, fetch_count}, 10);
    req_valid = 1; req_addr = 32'd0;
    tick;
    req_valid = 0; rst = 0;
    tick;
    rst = 1;
    chk("abort_cnt", {16'd0, fetch_count}, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_rv", {31'd0, resp_valid}, 0);
      tick;
    end
    do_fetch("after_abort", 32'd0, 32'h0409_0000, 0);
    chk("abort_cnt1", {16'd0, fetch_count}, 1);
    req_valid1 = 1; req_addr = 32'd0;
    tick;
    req_valid1 = 0;
    chk("l1_rv_n0", {31'd0, resp_valid1}, 0);
    tick;
    chk("l1_rv_n1", {31'd0, resp_valid1}, 1);
    chk("l1_data", resp_data1, 32'h0409_0000);
    resp_ready1 = 1;
    tick;
    resp_ready1 = 0;
    chk("l1_cnt", {16'd0, fetch_count1}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
